// File: rtl/mem_access_stage.sv
// Memory-access stage: turns ALU load/store results into a single-outstanding req/ack
// bus transaction, formats load data for writeback, and reports misalign / ack timeout.
module mem_access_stage #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            iClk,
   input  logic            iRst,
   input  logic            iValid,
   input  logic            iMemRead,
   input  logic            iMemWrite,
   input  logic [2:0]      iFunct3,
   input  logic [XLEN-1:0] iAddr,
   input  logic [XLEN-1:0] iWrData,
   input  logic [4:0]      iRdAddr,
   output logic            oStall,
   output logic            oMemReq,
   output logic            oMemWe,
   output logic [XLEN-1:0] oMemAddr,
   output logic [XLEN-1:0] oMemWdata,
   output logic [3:0]      oMemBe,
   input  logic            iMemAck,
   input  logic [XLEN-1:0] iMemRdata,
   output logic            oWbValid,
   output logic [4:0]      oWbRdAddr,
   output logic [XLEN-1:0] oWbData,
   output logic            oMisalign,
   output logic            oBusErr
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       off;
   logic [2:0]       f3;
   logic             is_load;
   logic [4:0]       rd;

   logic             size_b, size_h, misalign, accept;
   logic [3:0]       be_next;
   logic [XLEN-1:0]  wdata_next;
   logic [XLEN-1:0]  shifted, ld_data;
   logic             sx;

   assign oStall = (state != IDLE);
   assign accept = (state == IDLE) && iValid && (iMemRead || iMemWrite);

   // funct3[1:0] picks the size; 11 and the unused 11x codes fall through to word
   always_comb begin
      size_b     = (iFunct3[1:0] == 2'b00);
      size_h     = (iFunct3[1:0] == 2'b01);
      misalign   = size_h ? iAddr[0] : (!size_b && (iAddr[1:0] != 2'b00));
      be_next    = 4'b1111;
      wdata_next = iWrData;
      if (size_b) begin
         be_next    = 4'b0001 << iAddr[1:0];
         wdata_next = {(XLEN/8){iWrData[7:0]}};
      end else if (size_h) begin
         be_next    = 4'b0011 << iAddr[1:0];
         wdata_next = {(XLEN/16){iWrData[15:0]}};
      end
   end

   // Lane select uses the offset captured at accept, not the live address
   always_comb begin
      shifted = iMemRdata >> {off, 3'b000};
      sx      = ~f3[2];
      ld_data = iMemRdata;
      case (f3[1:0])
         2'b00:   ld_data = {{(XLEN-8){sx & shifted[7]}}, shifted[7:0]};
         2'b01:   ld_data = {{(XLEN-16){sx & shifted[15]}}, shifted[15:0]};
         default: ld_data = iMemRdata;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state     <= IDLE;
         cnt       <= '0;
         off       <= '0;
         f3        <= '0;
         is_load   <= 1'b0;
         rd        <= '0;
         oMemReq   <= 1'b0;
         oMemWe    <= 1'b0;
         oMemAddr  <= '0;
         oMemWdata <= '0;
         oMemBe    <= '0;
         oWbValid  <= 1'b0;
         oWbRdAddr <= '0;
         oWbData   <= '0;
         oMisalign <= 1'b0;
         oBusErr   <= 1'b0;
      end else begin
         oWbValid  <= 1'b0;
         oMisalign <= 1'b0;
         oBusErr   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (misalign) begin
                     oMisalign <= 1'b1;
                  end else begin
                     state     <= BUSY;
                     cnt       <= '0;
                     oMemReq   <= 1'b1;
                     oMemWe    <= iMemWrite && !iMemRead;
                     oMemAddr  <= {iAddr[XLEN-1:2], 2'b00};
                     oMemBe    <= be_next;
                     oMemWdata <= wdata_next;
                     off       <= iAddr[1:0];
                     f3        <= iFunct3;
                     is_load   <= iMemRead;
                     rd        <= iRdAddr;
                  end
               end
            end
            BUSY: begin
               // cnt holds (busy cycles - 1), so an ack in the TIMEOUT-th cycle still wins
               if (iMemAck) begin
                  state   <= IDLE;
                  oMemReq <= 1'b0;
                  oMemWe  <= 1'b0;
                  if (is_load && (rd != 5'd0)) begin
                     oWbValid  <= 1'b1;
                     oWbRdAddr <= rd;
                     oWbData   <= ld_data;
                  end
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state   <= IDLE;
                  oMemReq <= 1'b0;
                  oMemWe  <= 1'b0;
                  oBusErr <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver plays both the ALU and the memory,
// pushing expected bus requests and results; a negedge monitor pops and compares.
module tb_mem_access_stage;

   localparam int TIMEOUT = 16;
   localparam int K_WB = 0, K_MIS = 1, K_ERR = 2;

   logic        iClk, iRst, iValid, iMemRead, iMemWrite, iMemAck;
   logic [2:0]  iFunct3;
   logic [31:0] iAddr, iWrData, iMemRdata;
   logic [4:0]  iRdAddr;
   logic        oStall, oMemReq, oMemWe, oWbValid, oMisalign, oBusErr;
   logic [31:0] oMemAddr, oMemWdata, oWbData;
   logic [3:0]  oMemBe;
   logic [4:0]  oWbRdAddr;

   mem_access_stage #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
      .iClk(iClk), .iRst(iRst), .iValid(iValid), .iMemRead(iMemRead),
      .iMemWrite(iMemWrite), .iFunct3(iFunct3), .iAddr(iAddr), .iWrData(iWrData),
      .iRdAddr(iRdAddr), .oStall(oStall), .oMemReq(oMemReq), .oMemWe(oMemWe),
      .oMemAddr(oMemAddr), .oMemWdata(oMemWdata), .oMemBe(oMemBe), .iMemAck(iMemAck),
      .iMemRdata(iMemRdata), .oWbValid(oWbValid), .oWbRdAddr(oWbRdAddr),
      .oWbData(oWbData), .oMisalign(oMisalign), .oBusErr(oBusErr)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   typedef struct {int kind; logic [4:0] rd; logic [31:0] data;} res_t;
   typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;
   res_t res_q[$];
   bus_t bus_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: access size in bytes, then plain shifts and masks
   function automatic int nbytes(input logic [2:0] f);
      if (f == 3'd0 || f == 3'd4) return 1;
      if (f == 3'd1 || f == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
      int n = nbytes(f);
      int v = ((1 << n) - 1) << (a % 4);
      return 4'(v);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
      logic [31:0] r;
      int n = nbytes(f);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] w);
      logic [31:0] v = w >> (8 * (a % 4));
      int n = nbytes(f);
      if (n == 1) begin
         v = v & 32'h0000_00FF;
         if (f == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (n == 2) begin
         v = v & 32'h0000_FFFF;
         if (f == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else v = w;
      return v;
   endfunction

   // Monitor
   logic prev_req = 1'b0;
   always @(negedge iClk) begin
      bus_t b;
      res_t r;
      int   kind;
      if (oMemReq === 1'b1 && !prev_req) begin
         if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
         else begin
            b = bus_q.pop_front();
            check("bus_addr", oMemAddr, b.addr);
            check("bus_we", {31'd0, oMemWe}, {31'd0, b.we});
            check("bus_be", {28'd0, oMemBe}, {28'd0, b.be});
            if (b.we) check("bus_wdata", oMemWdata, b.wdata);
         end
      end
      if (oWbValid === 1'b1 || oMisalign === 1'b1 || oBusErr === 1'b1) begin
         kind = oWbValid ? K_WB : (oMisalign ? K_MIS : K_ERR);
         if (res_q.size() == 0) check("event_unexpected", kind, 99);
         else begin
            r = res_q.pop_front();
            check("event_kind", kind, r.kind);
            if (r.kind == K_WB) begin
               check("wb_rd", {27'd0, oWbRdAddr}, {27'd0, r.rd});
               check("wb_data", oWbData, r.data);
            end
         end
      end
      prev_req = (oMemReq === 1'b1);
   end

   // Issue one op at a negedge; returns at the negedge where the stage is idle again
   task automatic issue(input bit rd_op, input bit wr_op, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rda,
                        input int delay, input logic [31:0] rdata);
      bit mis = (a % nbytes(f)) != 0;
      int stall_cnt = 0;
      int c = 1;
      int exp_stall;
      int guard = 0;
      while (oStall && guard < 50) begin
         @(negedge iClk);
         guard++;
      end
      iValid = 1'b1; iMemRead = rd_op; iMemWrite = wr_op;
      iFunct3 = f; iAddr = a; iWrData = d; iRdAddr = rda;
      if (mis) res_q.push_back('{K_MIS, 5'd0, 32'd0});
      else begin
         bus_q.push_back('{!rd_op, {a[31:2], 2'b00}, model_be(f, a), model_wdata(f, d)});
         if (delay >= TIMEOUT) res_q.push_back('{K_ERR, 5'd0, 32'd0});
         else if (rd_op && rda != 5'd0) res_q.push_back('{K_WB, rda, model_load(f, a, rdata)});
      end
      @(negedge iClk);
      iValid = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
      iAddr = $urandom; iWrData = $urandom; iFunct3 = 3'($urandom); iRdAddr = 5'($urandom);
      if (mis) begin
         check("mis_req", {31'd0, oMemReq}, 0);
         check("mis_stall", {31'd0, oStall}, 0);
         return;
      end
      check("req_rise", {31'd0, oMemReq}, 1);
      while (oStall && c <= TIMEOUT + 5) begin
         stall_cnt++;
         iMemAck   = (c == delay + 1);
         iMemRdata = (c == delay + 1) ? rdata : $urandom;
         @(negedge iClk);
         c++;
      end
      iMemAck = 1'b0;
      exp_stall = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
      check("stall_cycles", stall_cnt, exp_stall);
      check("req_drop", {31'd0, oMemReq}, 0);
      if (delay >= TIMEOUT) check("bus_err_pulse", {31'd0, oBusErr}, 1);
      else check("wb_latency", {31'd0, oWbValid}, {31'd0, rd_op && rda != 5'd0});
   endtask

   task automatic idle_noise();
      iValid = $urandom_range(0, 1); iMemAck = $urandom_range(0, 1); iMemRdata = $urandom;
      @(negedge iClk);
      iValid = 1'b0; iMemAck = 1'b0;
   endtask

   logic [2:0] fsel[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

   initial begin
      iRst = 1'b1; iValid = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0; iMemAck = 1'b0;
      iFunct3 = 3'd0; iAddr = '0; iWrData = '0; iRdAddr = '0; iMemRdata = '0;
      repeat (2) @(negedge iClk);
      check("rst_req", {31'd0, oMemReq}, 0);
      check("rst_stall", {31'd0, oStall}, 0);
      check("rst_addr", oMemAddr, 0);
      check("rst_be", {28'd0, oMemBe}, 0);
      check("rst_wbdata", oWbData, 0);
      iRst = 1'b0;
      @(negedge iClk);

      issue(1, 0, 3'd2, 32'h100, 0, 5'd5, 0, 32'hDEADBEEF);
      check("t1_lw_data", oWbData, 32'hDEADBEEF);
      issue(1, 0, 3'd0, 32'h103, 0, 5'd6, 1, 32'h80FF_FF00);
      check("t2_lb_data", oWbData, 32'hFFFF_FF80);
      issue(1, 0, 3'd4, 32'h103, 0, 5'd7, 3, 32'h80FF_FF00);
      check("t2_lbu_data", oWbData, 32'h0000_0080);
      issue(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 5'd8, 2, 0);
      issue(1, 0, 3'd2, 32'h101, 0, 5'd9, 0, 0);
      issue(1, 0, 3'd2, 32'h300, 0, 5'd10, TIMEOUT, 0);
      issue(1, 0, 3'd2, 32'h304, 0, 5'd11, TIMEOUT - 1, 32'h0BAD_F00D);
      issue(1, 0, 3'd2, 32'h308, 0, 5'd12, 2, 32'h5555_AAAA);
      issue(1, 0, 3'd2, 32'h30C, 0, 5'd0, 1, 32'h1);

      // Reset while busy drops the transaction; a late ack must be ignored
      bus_q.push_back('{1'b0, 32'h400, 4'b1111, 32'd0});
      iValid = 1'b1; iMemRead = 1'b1; iFunct3 = 3'd2; iAddr = 32'h400; iRdAddr = 5'd3;
      @(negedge iClk);
      iValid = 1'b0; iMemRead = 1'b0;
      @(negedge iClk);
      iRst = 1'b1;
      @(negedge iClk);
      iRst = 1'b0;
      check("midrst_req", {31'd0, oMemReq}, 0);
      check("midrst_stall", {31'd0, oStall}, 0);
      check("midrst_we_be", {27'd0, oMemWe, oMemBe}, 0);
      check("midrst_evt", {29'd0, oWbValid, oMisalign, oBusErr}, 0);
      iMemAck = 1'b1; iMemRdata = 32'hFFFF_FFFF;
      @(negedge iClk);
      iMemAck = 1'b0;
      @(negedge iClk);

      for (int i = 0; i < 150; i++) begin
         int op = $urandom_range(0, 2);
         int dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(0, 5);
         issue(op != 1, op != 0, fsel[$urandom_range(0, 7)], $urandom, $urandom,
               5'($urandom), dly, $urandom);
         if ($urandom_range(0, 3) == 0) idle_noise();
      end
      repeat (3) @(negedge iClk);
      check("res_q_empty", res_q.size(), 0);
      check("bus_q_empty", bus_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
